// File: rtl/bus_req_ctrl.sv
// MESI bus requester: looks up the line state for a processor access, issues
// BusRd/BusRdX/BusUpgr to the arbiter on a miss, and writes back the new state.
package mesi_types;
    typedef enum logic [1:0] {
        No_OP   = 2'b00,
        BusRd   = 2'b01,
        BusRdX  = 2'b10,
        BusUpgr = 2'b11
    } bus_request;
endpackage

// state     | meaning
// IDLE      | ready for a processor access
// LOOKUP    | classify hit/miss from line_state at the latched address
// REQ       | drive latched command/address to the arbiter for one cycle
// GRANT_CHK | compare arbiter grant against our port and address
// RESP      | write new MESI state and signal completion
module bus_req_ctrl
    import mesi_types::*;
#(
    parameter int CACHE_ID = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_req_valid,
    input  logic       cpu_req_rw,
    input  logic [7:0] cpu_req_addr,
    output logic       cpu_req_ready,
    output logic       cpu_done,
    output logic [7:0] lk_addr,
    input  logic [1:0] line_state,
    output logic       state_wr_en,
    output logic [7:0] state_wr_addr,
    output logic [1:0] state_wr_val,
    output bus_request cmd_in,
    output logic [7:0] bus_addr,
    input  logic [1:0] bus_owner,
    input  logic [7:0] addr_out,
    input  logic       shared_in,
    output logic [3:0] retry_cnt
);

    localparam logic [1:0] ST_I = 2'b00;
    localparam logic [1:0] ST_S = 2'b01;
    localparam logic [1:0] ST_E = 2'b10;
    localparam logic [1:0] ST_M = 2'b11;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        REQ       = 3'd2,
        GRANT_CHK = 3'd3,
        RESP      = 3'd4
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] lat_addr;
    logic       lat_rw;
    bus_request lat_cmd;
    bus_request miss_cmd;
    logic       granted;

    // No_OP here means the access is a hit and needs no bus transaction
    always_comb begin
        miss_cmd = No_OP;
        if (line_state == ST_I)
            miss_cmd = lat_rw ? BusRdX : BusRd;
        else if (lat_rw && line_state == ST_S)
            miss_cmd = BusUpgr;
    end

    assign granted = bus_owner[CACHE_ID] && (addr_out == lat_addr);
    assign lk_addr = lat_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lat_addr  <= 8'h00;
            lat_rw    <= 1'b0;
            lat_cmd   <= No_OP;
            retry_cnt <= 4'd0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && cpu_req_valid) begin
                lat_addr  <= cpu_req_addr;
                lat_rw    <= cpu_req_rw;
                retry_cnt <= 4'd0;
            end
            if (state == LOOKUP)
                lat_cmd <= miss_cmd;
            if (state == GRANT_CHK && !granted && retry_cnt != 4'd15)
                retry_cnt <= retry_cnt + 4'd1;
        end
    end

    always_comb begin
        state_nxt     = state;
        cpu_req_ready = 1'b0;
        cpu_done      = 1'b0;
        state_wr_en   = 1'b0;
        state_wr_addr = 8'h00;
        state_wr_val  = ST_I;
        cmd_in        = No_OP;
        bus_addr      = 8'h00;
        case (state)
            IDLE: begin
                cpu_req_ready = 1'b1;
                if (cpu_req_valid)
                    state_nxt = LOOKUP;
            end
            LOOKUP: begin
                if (miss_cmd == No_OP) begin
                    cpu_done  = 1'b1;
                    state_nxt = IDLE;
                    if (lat_rw && line_state == ST_E) begin
                        state_wr_en   = 1'b1;
                        state_wr_addr = lat_addr;
                        state_wr_val  = ST_M;
                    end
                end else begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                cmd_in    = lat_cmd;
                bus_addr  = lat_addr;
                state_nxt = GRANT_CHK;
            end
            GRANT_CHK: begin
                state_nxt = granted ? RESP : REQ;
            end
            RESP: begin
                state_wr_en   = 1'b1;
                state_wr_addr = lat_addr;
                state_wr_val  = (lat_cmd == BusRd) ? (shared_in ? ST_S : ST_E) : ST_M;
                cpu_done      = 1'b1;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
